cms_row_counter: RTL and testbench

// One row of the count-min sketch hotness profiler. Sits directly downstream of the per-row

---
 rtl/cms_row_counter.sv | 174 +++++++++++++++++
 tb/tb_cms_row_counter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cms_row_counter.sv
// One count-min sketch row: saturating read-modify-write counter RAM
// with one-back forwarding, epoch clear sweep and a dropped-request count.
`timescale 1ns/1ps
module cms_row_counter #(
  parameter int HASH_WIDTH = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int KEY_WIDTH  = 28,
  parameter int DROP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [HASH_WIDTH-1:0] idx_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic [KEY_WIDTH-1:0]  key_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o
);

  localparam int DEPTH = 1 << HASH_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;
  localparam logic [HASH_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    SWEEP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  vld;
    logic [HASH_WIDTH-1:0] idx;
    logic [KEY_WIDTH-1:0]  key;
  } stg_a_t;

  state_t                state_q;
  state_t                state_d;
  logic [HASH_WIDTH-1:0] swp_addr_q;
  logic [HASH_WIDTH-1:0] swp_addr_d;

  stg_a_t                a_q;
  logic [HASH_WIDTH-1:0] wr_idx_q;

  logic [CNT_WIDTH-1:0]  mem [DEPTH];
  logic [CNT_WIDTH-1:0]  rd_data_q;

  logic                  busy;
  logic                  accept;
  logic                  fwd;
  logic [CNT_WIDTH-1:0]  src;
  logic [CNT_WIDTH-1:0]  upd;
  logic                  mem_we;
  logic [HASH_WIDTH-1:0] mem_waddr;
  logic [CNT_WIDTH-1:0]  mem_wdata;

  assign busy   = (state_q != IDLE);
  assign busy_o = busy;
  assign accept = valid_i & ~busy;

  // The write landing at the read edge is invisible to the RAM read,
  // so take it from the output register instead.
  assign fwd = valid_o & (a_q.idx == wr_idx_q);
  assign src = fwd ? cnt_o : rd_data_q;
  assign upd = (src == CNT_MAX) ? CNT_MAX : src + 1'b1;

  // Stage A completions own the write port; the sweep only runs
  // once the pipeline is empty.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = swp_addr_q;
    mem_wdata = '0;
    if (a_q.vld) begin
      mem_we    = 1'b1;
      mem_waddr = a_q.idx;
      mem_wdata = upd;
    end else if (state_q == SWEEP) begin
      mem_we    = 1'b1;
    end
  end

  // Counter RAM: synchronous read on accept, single write port.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data_q <= mem[idx_i];
    end
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Stage A: hold index and key while the RAM read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
    end else begin
      a_q.vld <= accept;
      if (accept) begin
        a_q.idx <= idx_i;
        a_q.key <= key_i;
      end
    end
  end

  // Output stage: publish the updated count and remember its index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      cnt_o    <= '0;
      key_o    <= '0;
      wr_idx_q <= '0;
    end else begin
      valid_o <= a_q.vld;
      if (a_q.vld) begin
        cnt_o    <= upd;
        key_o    <= a_q.key;
        wr_idx_q <= a_q.idx;
      end
    end
  end

  // Saturating count of requests refused while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_o <= '0;
    end else if (valid_i && busy && (drop_cnt_o != DROP_MAX)) begin
      drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  // Control state register; reset starts a full sweep from address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SWEEP;
      swp_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      swp_addr_q <= swp_addr_d;
    end
  end

  // Next state: wait for the pipeline to empty, then zero every counter.
  always_comb begin
    state_d    = state_q;
    swp_addr_d = swp_addr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!a_q.vld) begin
          state_d    = SWEEP;
          swp_addr_d = '0;
        end
      end
      SWEEP: begin
        swp_addr_d = swp_addr_q + 1'b1;
        if (swp_addr_q == ADDR_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = SWEEP;
        swp_addr_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cms_row_counter.sv
// Bench for cms_row_counter: directed tables, clear/drop/reset
// sequences and random traffic against an array-based count model.
`timescale 1ns/1ps
module tb_cms_row_counter;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [9:0]  idx_i;
  logic [27:0] key_i;
  logic        clear_i;
  logic        busy_o;
  logic        valid_o;
  logic [15:0] cnt_o;
  logic [27:0] key_o;
  logic [15:0] drop_cnt_o;

  logic        s_valid;
  logic [3:0]  s_idx;
  logic [27:0] s_key;
  logic        s_clear;
  logic        s_busy;
  logic        s_valid_o;
  logic [3:0]  s_cnt;
  logic [27:0] s_key_o;
  logic [15:0] s_drop;

  cms_row_counter #(
    .HASH_WIDTH(10), .CNT_WIDTH(16), .KEY_WIDTH(28), .DROP_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .idx_i(idx_i),
    .key_i(key_i), .clear_i(clear_i), .busy_o(busy_o),
    .valid_o(valid_o), .cnt_o(cnt_o), .key_o(key_o),
    .drop_cnt_o(drop_cnt_o)
  );

  cms_row_counter #(
    .HASH_WIDTH(4), .CNT_WIDTH(4), .KEY_WIDTH(28), .DROP_WIDTH(16)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .valid_i(s_valid), .idx_i(s_idx),
    .key_i(s_key), .clear_i(s_clear), .busy_o(s_busy),
    .valid_o(s_valid_o), .cnt_o(s_cnt), .key_o(s_key_o),
    .drop_cnt_o(s_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int unsigned mcnt [1024];
  bit          e1_v, e2_v;
  int unsigned e1_c, e2_c;
  logic [27:0] e1_k, e2_k;
  int unsigned mdrop;
  int          msweep;
  bit          unk;

  logic        obs_v;
  logic [15:0] obs_cnt;
  logic [27:0] obs_key;
  logic        obs_busy;
  logic        w_v2;
  logic [15:0] w_cnt2;

  typedef struct {
    bit          v;
    int          idx;
    logic [27:0] key;
    bit          ev;
    int unsigned ecnt;
    logic [27:0] ekey;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mcnt[i] = 0;
    e1_v = 0; e2_v = 0;
    e1_c = 0; e2_c = 0;
    e1_k = '0; e2_k = '0;
    mdrop = 0;
    unk = 0;
  endtask

  // One clock cycle: drive, check at negedge, advance model, step.
  task automatic cyc(input bit v, input int idx, input logic [27:0] key,
                     input bit clr);
    bit mb;
    int unsigned c;
    valid_i = v;
    idx_i   = idx[9:0];
    key_i   = key;
    clear_i = clr;
    @(negedge clk);
    obs_v    = valid_o;
    obs_cnt  = cnt_o;
    obs_key  = key_o;
    obs_busy = busy_o;
    chk("valid_o", valid_o, e2_v);
    if (e2_v) begin
      chk("cnt_o", cnt_o, e2_c);
      chk("key_o", key_o, e2_k);
    end
    chk("drop_cnt_o", drop_cnt_o, mdrop);
    mb = unk ? 1'b1 : (msweep > 0);
    if (!unk) chk("busy_o", busy_o, mb);
    e2_v = e1_v; e2_c = e1_c; e2_k = e1_k;
    e1_v = 0;
    if (v && !mb) begin
      c = mcnt[idx];
      if (c < 65535) c = c + 1;
      mcnt[idx] = c;
      e1_v = 1; e1_c = c; e1_k = key;
    end
    if (v && mb && mdrop < 65535) mdrop++;
    if (clr && !mb) begin
      for (int i = 0; i < 1024; i++) mcnt[i] = 0;
      unk = 1;
    end
    if (!unk && msweep > 0) msweep--;
    @(posedge clk);
    #1;
  endtask

  // Run through drain + sweep after a clear, optional drop pulses
  // and an ignored re-clear inside the busy window.
  task automatic wait_idle(input int p_start, input int p_n,
                           input int clr_at);
    int  n;
    bit  done;
    bit  v;
    cyc(0, 0, '0, 0);
    chk("busy_rise", obs_busy, 1);
    n = 1;
    done = 0;
    while (!done && n < 1200) begin
      v = (n >= p_start) && (n < p_start + p_n);
      cyc(v, 11, 28'(n), n == clr_at);
      if (n == 1) begin
        w_v2   = obs_v;
        w_cnt2 = obs_cnt;
      end
      n++;
      if (!obs_busy) done = 1;
    end
    chk("busy_fall_seen", done, 1);
    chk("busy_len_ok", ((n - 1) >= 1025) && ((n - 1) <= 1026), 1);
    unk = 0;
    msweep = 0;
  endtask

  initial begin
    int nb;
    int exp_s;
    logic [27:0] k;
    n_chk = 0;
    n_fail = 0;
    model_reset();
    msweep = 0;
    rst_n = 0;
    valid_i = 0; idx_i = '0; key_i = '0; clear_i = 0;
    s_valid = 0; s_idx = '0; s_key = '0; s_clear = 0;

    @(negedge clk);
    chk("rst_busy", busy_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_key", key_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    msweep = 1024;

    nb = 0;
    for (int i = 0; i < 1030; i++) begin
      cyc(0, 0, '0, 0);
      nb += int'(obs_busy);
    end
    chk("reset_sweep_len", nb, 1024);

    foreach (tv[i]) begin
      tv[i] = '{0, 0, '0, 0, 0, '0};
    end
    for (int j = 0; j < 3; j++) begin
      int ix;
      ix = (j == 0) ? 0 : (j == 1) ? 5 : 1023;
      k = 28'h0A0_0000 + 28'(ix);
      cyc(1, ix, k, 0);
      cyc(0, 0, '0, 0);
      cyc(0, 0, '0, 0);
      chk("t1_valid", obs_v, 1);
      chk("t1_cnt", obs_cnt, 1);
      chk("t1_key", obs_key, k);
    end

    tv[0]  = '{1, 7,  28'h10, 0, 0, '0};
    tv[1]  = '{1, 7,  28'h11, 0, 0, '0};
    tv[2]  = '{1, 7,  28'h12, 1, 1, 28'h10};
    tv[3]  = '{1, 7,  28'h13, 1, 2, 28'h11};
    tv[4]  = '{0, 0,  28'h0,  1, 3, 28'h12};
    tv[5]  = '{0, 0,  28'h0,  1, 4, 28'h13};
    tv[6]  = '{0, 0,  28'h0,  0, 0, '0};
    tv[7]  = '{1, 40, 28'h20, 0, 0, '0};
    tv[8]  = '{1, 41, 28'h21, 0, 0, '0};
    tv[9]  = '{1, 40, 28'h22, 1, 1, 28'h20};
    tv[10] = '{0, 0,  28'h0,  1, 1, 28'h21};
    tv[11] = '{0, 0,  28'h0,  1, 2, 28'h22};
    tv[12] = '{0, 0,  28'h0,  0, 0, '0};
    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].v, tv[i].idx, tv[i].key, 0);
      chk("tbl_valid", obs_v, tv[i].ev);
      if (tv[i].ev) begin
        chk("tbl_cnt", obs_cnt, tv[i].ecnt);
        chk("tbl_key", obs_key, tv[i].ekey);
      end
    end

    chk("sat_idle", s_busy, 0);
    for (int i = 0; i < 23; i++) begin
      s_valid = (i < 20);
      s_idx = 4'd3;
      s_key = 28'(i);
      @(negedge clk);
      if (i >= 2 && i < 22) begin
        exp_s = (i - 1 > 15) ? 15 : i - 1;
        chk("sat_valid", s_valid_o, 1);
        chk("sat_cnt", s_cnt, exp_s);
        chk("sat_key", s_key_o, i - 2);
      end else begin
        chk("sat_valid_idle", s_valid_o, 0);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 0;

    cyc(1, 9, 28'h901, 0);
    cyc(1, 9, 28'h902, 0);
    cyc(1, 9, 28'h903, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    cyc(1, 9, 28'h904, 1);
    wait_idle(0, 0, -1);
    chk("t4_inflight_valid", w_v2, 1);
    chk("t4_inflight_cnt", w_cnt2, 4);
    cyc(1, 9, 28'h905, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    chk("t4_after_clear", obs_cnt, 1);

    cyc(0, 0, '0, 1);
    wait_idle(100, 10, 500);
    chk("t5_drops", drop_cnt_o, 10);
    cyc(0, 0, '0, 1);
    wait_idle(0, 0, -1);
    chk("t5_drops_kept", drop_cnt_o, 10);

    for (int i = 0; i < 3000; i++) begin
      bit v;
      int ix;
      v = ($urandom_range(0, 9) < 7);
      ix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                       : int'($urandom_range(0, 5));
      cyc(v, ix, 28'($urandom), 0);
    end
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);

    cyc(1, 3, 28'hA1, 0);
    cyc(1, 4, 28'hA2, 0);
    chk("pre_rst_valid", valid_o, 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_busy", busy_o, 1);
    chk("mid_rst_cnt", cnt_o, 0);
    chk("mid_rst_key", key_o, 0);
    chk("mid_rst_drop", drop_cnt_o, 0);
    valid_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    msweep = 1024;
    nb = 0;
    for (int i = 0; i < 1030; i++) begin
      cyc(0, 0, '0, 0);
      nb += int'(obs_busy);
    end
    chk("rst2_sweep_len", nb, 1024);
    cyc(1, 3, 28'hB3, 0);
    cyc(0, 0, '0, 0);
    cyc(0, 0, '0, 0);
    chk("rst2_cnt", obs_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
